// File: rtl/romq_unpack_pipe.sv
// ROM-Q unpack + lane rotate with a registered 1-stage output and 2-entry skid (valid/ready).
// Optional macro ROMQ_BITREV_EN bit-reverses the rotated lane index (DIF stage ordering).
module romq_unpack_pipe #(
    parameter int unsigned D_WIDTH = 64,
    parameter int unsigned PACK    = 2,
    parameter int unsigned N_BANKS = 8,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned LANES  = N_BANKS * PACK,
    localparam int unsigned ROT_W  = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned IN_W   = LANES * D_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_q,
    input  logic [ROT_W-1:0]   in_rot,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IN_W-1:0]    out_lanes,
    output logic [CNT_W-1:0]   beat_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    m_q, m_d;
    logic [IN_W-1:0]    s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [D_WIDTH-1:0] u_c [LANES];
    logic [IN_W-1:0]    rot_c;
    logic               accept_c;
    logic               deliver_c;

`ifdef ROMQ_BITREV_EN
    function automatic logic [ROT_W-1:0] bitrev(input logic [ROT_W-1:0] x);
        logic [ROT_W-1:0] r;
        for (int i = 0; i < int'(ROT_W); i++) begin
            r[i] = x[int'(ROT_W) - 1 - i];
        end
        return r;
    endfunction
`endif

    // Unpack banks into lanes (sub-word 0 is the MSB slice), then rotate.
    always_comb begin
        for (int b = 0; b < int'(N_BANKS); b++) begin
            for (int k = 0; k < int'(PACK); k++) begin
                u_c[b*int'(PACK) + k] =
                    in_q[(b*int'(PACK) + (int'(PACK) - 1 - k))*int'(D_WIDTH) +: D_WIDTH];
            end
        end
        rot_c = '0;
        for (int j = 0; j < int'(LANES); j++) begin : g_lane
            logic [ROT_W-1:0] idx;
            if (LANES > 1) begin
                idx = ROT_W'(j) + in_rot;
            end else begin
                idx = '0;
            end
`ifdef ROMQ_BITREV_EN
            idx = bitrev(idx);
`endif
            rot_c[j*int'(D_WIDTH) +: D_WIDTH] = u_c[idx];
        end
    end

    assign accept_c  = in_valid && in_ready_q;
    assign deliver_c = out_valid_q && out_ready;

    // Next-state for the M/S skid buffer and delivered-beat counter.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    m_d     = rot_c;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && deliver_c) begin
                    m_d = rot_c;
                end else if (accept_c) begin
                    s_d     = rot_c;
                    state_d = ST_TWO;
                end else if (deliver_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver_c) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (deliver_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_lanes = m_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_romq_unpack_pipe.sv
// Bench for romq_unpack_pipe (D_WIDTH=8, PACK=2, N_BANKS=2, CNT_W=4): queue model + directed literals.
module tb_romq_unpack_pipe;

    localparam int DW = 8;
    localparam int PK = 2;
    localparam int NB = 2;
    localparam int CW = 4;
    localparam int LN = NB * PK;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_q;
    logic [1:0]        in_rot;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_lanes;
    logic [CW-1:0]     beat_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [31:0] mq[$];
    int          mcnt = 0;

    romq_unpack_pipe #(
        .D_WIDTH (DW),
        .PACK    (PK),
        .N_BANKS (NB),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lanes (out_lanes),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    // Expected lane word: lane j takes unpacked word (j+rot) mod LANES.
    function automatic logic [31:0] exp_lanes(input logic [31:0] q, input int rot);
        logic [31:0] r;
        int src, bank, k;
        r = '0;
        for (int j = 0; j < LN; j++) begin
            src = (j + rot) % LN;
`ifdef ROMQ_BITREV_EN
            src = ((src & 1) << 1) | ((src >> 1) & 1);
`endif
            bank = src / PK;
            k    = src % PK;
            r[j*DW +: DW] = q[bank*PK*DW + (PK-1-k)*DW +: DW];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two beats; accept only when fewer than two were held.
    always @(posedge clk) begin
        bit dlv, acc;
        if (!rst_n) begin
            mq.delete();
            mcnt = 0;
        end else begin
            dlv = (mq.size() > 0) && out_ready;
            acc = in_valid && (mq.size() < 2);
            if (dlv) begin
                void'(mq.pop_front());
                mcnt = (mcnt + 1) % (1 << CW);
            end
            if (acc) mq.push_back(exp_lanes(in_q, int'(in_rot)));
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mdl_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("mdl_in_ready", 32'(in_ready), 32'(mq.size() < 2));
            chk("mdl_beat_cnt", 32'(beat_cnt), 32'(mcnt));
            if (mq.size() > 0) chk("mdl_out_lanes", out_lanes, mq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] r);
        bit acc;
        int n;
        tick();
        in_valid = 1'b1;
        in_q     = d;
        in_rot   = r;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted data=%h", d);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_q      = '0;
        in_rot    = '0;
        out_ready = 1'b0;

        // Reset
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_lanes", out_lanes, 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Unpack, no rotation: lanes 0..3 = B1,B2,A1,A2
        out_ready = 1'b1;
        send(32'hA1A2_B1B2, 2'd0);
        @(negedge clk);
        chk("unpack_valid", 32'(out_valid), 32'd1);
`ifdef ROMQ_BITREV_EN
        chk("unpack_bitrev_lanes", out_lanes, 32'hA2B2_A1B1);
`else
        chk("unpack_lanes", out_lanes, 32'hA2A1_B2B1);
`endif
        tick();
        @(negedge clk);
        chk("unpack_beat_cnt", 32'(beat_cnt), 32'd1);

        // Rotate by one: lanes 0..3 = B2,A1,A2,B1
        send(32'hA1A2_B1B2, 2'd1);
        @(negedge clk);
`ifndef ROMQ_BITREV_EN
        chk("rot1_lanes", out_lanes, 32'hB1A2_A1B2);
`endif
        tick();
        @(negedge clk);
        chk("rot1_beat_cnt", 32'(beat_cnt), 32'd2);

        // Backpressure: P,Q taken, R held off while out_lanes stays P
        out_ready = 1'b0;
        send(32'h1122_3344, 2'd0);
        send(32'h5566_7788, 2'd2);
        in_valid = 1'b1;
        in_q     = 32'h99AA_BBCC;
        in_rot   = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
`ifndef ROMQ_BITREV_EN
            chk("bp_hold_p", out_lanes, 32'h2211_4433);
`endif
            tick();
        end
        out_ready = 1'b1;
        send(32'h99AA_BBCC, 2'd3);
        repeat (4) tick();
        @(negedge clk);
        chk("bp_drain_cnt", 32'(beat_cnt), 32'd5);
        chk("bp_drain_empty", 32'(out_valid), 32'd0);

        // Counter wrap: 17 deliveries from reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(32'(i) * 32'h0101_0101 + 32'h0011_2233, 2'(i));
        end
        repeat (4) tick();
        @(negedge clk);
        chk("wrap_beat_cnt", 32'(beat_cnt), 32'd1);

        // Reset while two beats are buffered
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 2'd0);
        send(32'hCAFE_F00D, 2'd1);
        @(negedge clk);
        chk("mid_full_ready", 32'(in_ready), 32'd0);
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(beat_cnt), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
